ir_regbank: RTL and testbench

Front-end datapath block of the multicycle MIPS-style CPU: a 32-bit instruction register with field decode, fused with a 32×32-bit general-purpose register bank. The register bank's two read ports are addressed directly by the rs/rt fields of the latched instruction. It feeds the A/B operand registers, and its decoded fields drive the control unit, the sign extender, the jump logic and the RegDst multiplexer.

---
 rtl/ir_regbank.sv | 71 +++++++
 tb/tb_ir_regbank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_regbank.sv
// Instruction register with field decode fused with a 32x32 register bank ($0 hardwired to zero).
// Optional IRB_WRITE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module ir_regbank (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_write,
  input  logic [31:0] mem_data,
  input  logic        reg_wr,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b
);

  localparam logic [4:0]  SpIdx   = 5'd29;
  localparam logic [31:0] SpReset = 32'd227;

  logic [31:0] instrQ;
  logic [31:0] regsQ [32];
  logic        wrEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrQ <= '0;
    end else if (ir_write) begin
      instrQ <= mem_data;
    end
  end

  assign opcode = instrQ[31:26];
  assign rs     = instrQ[25:21];
  assign rt     = instrQ[20:16];
  assign rd     = instrQ[15:11];
  assign shamt  = instrQ[10:6];
  assign funct  = instrQ[5:0];
  assign imm    = instrQ[15:0];

  // Writes to $0 are dropped here so the entry stays at its reset value of zero.
  assign wrEn = reg_wr && (write_reg != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regsQ[i] <= (5'(i) == SpIdx) ? SpReset : 32'd0;
      end
    end else if (wrEn) begin
      regsQ[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data_a = (rs == 5'd0) ? 32'd0 : regsQ[rs];
    read_data_b = (rt == 5'd0) ? 32'd0 : regsQ[rt];
`ifdef IRB_WRITE_BYPASS_EN
    if (wrEn && (write_reg == rs)) begin
      read_data_a = write_data;
    end
    if (wrEn && (write_reg == rt)) begin
      read_data_b = write_data;
    end
`endif
  end

endmodule

// File: tb/tb_ir_regbank.sv
// Scoreboard bench for ir_regbank: stimulus queues expectations, a negedge monitor checks them.
module tb_ir_regbank;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_write;
  logic [31:0] mem_data;
  logic        reg_wr;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;

  ir_regbank dut (
    .clk        (clk),
    .reset      (reset),
    .ir_write   (ir_write),
    .mem_data   (mem_data),
    .reg_wr     (reg_wr),
    .write_reg  (write_reg),
    .write_data (write_data),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm        (imm),
    .read_data_a(read_data_a),
    .read_data_b(read_data_b)
  );

  always #5 clk = ~clk;

  localparam int SigA = 0, SigB = 1, SigOp = 2, SigRs = 3, SigRt = 4, SigRd = 5,
                 SigSh = 6, SigFn = 7, SigImm = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } expect_t;

  expect_t sbQ[$];
  int nChecks = 0;
  int nErrors = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SigA:    return read_data_a;
      SigB:    return read_data_b;
      SigOp:   return 32'(opcode);
      SigRs:   return 32'(rs);
      SigRt:   return 32'(rt);
      SigRd:   return 32'(rd);
      SigSh:   return 32'(shamt);
      SigFn:   return 32'(funct);
      default: return 32'(imm);
    endcase
  endfunction

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    expect_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  // Monitor: all outputs are combinational, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      expect_t e;
      logic [31:0] got;
      e = sbQ.pop_front();
      got = observe(e.sel);
      nChecks++;
      if (got !== e.val) begin
        nErrors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ir_write = 1'b0; mem_data = '0;
    reg_wr = 1'b0; write_reg = '0; write_data = '0;
    tick();
    tick();
    expect_val("rst_a", SigA, 32'd0);
    expect_val("rst_b", SigB, 32'd0);
    expect_val("rst_op", SigOp, 32'd0);
    expect_val("rst_imm", SigImm, 32'd0);
    tick();
    reset = 1'b0;

    // $sp reset value through rs=29
    ir_write = 1'b1; mem_data = 32'h03A0_F820;
    tick();
    ir_write = 1'b0;
    expect_val("sp_a", SigA, 32'd227);
    expect_val("sp_b", SigB, 32'd0);
    expect_val("sp_op", SigOp, 32'd0);
    expect_val("sp_rs", SigRs, 32'd29);
    expect_val("sp_rt", SigRt, 32'd0);
    expect_val("sp_rd", SigRd, 32'd31);
    expect_val("sp_sh", SigSh, 32'd0);
    expect_val("sp_fn", SigFn, 32'd32);
    tick();

    // IR load then hold
    ir_write = 1'b1; mem_data = 32'h8D2A_0004;
    tick();
    ir_write = 1'b0; mem_data = 32'hFFFF_FFFF;
    expect_val("ld_op", SigOp, 32'h23);
    expect_val("ld_rs", SigRs, 32'd9);
    expect_val("ld_rt", SigRt, 32'd10);
    expect_val("ld_imm", SigImm, 32'h4);
    expect_val("ld_a", SigA, 32'd0);
    tick();
    expect_val("hold_op", SigOp, 32'h23);
    expect_val("hold_rs", SigRs, 32'd9);
    expect_val("hold_rt", SigRt, 32'd10);
    expect_val("hold_imm", SigImm, 32'h4);

    // Write reg 9 then reg 10
    reg_wr = 1'b1; write_reg = 5'd9; write_data = 32'hDEAD_BEEF;
`ifdef IRB_WRITE_BYPASS_EN
    expect_val("wr9_pre_a", SigA, 32'hDEAD_BEEF);
`else
    expect_val("wr9_pre_a", SigA, 32'd0);
`endif
    tick();
    write_reg = 5'd10; write_data = 32'h1234_5678;
    expect_val("wr9_a", SigA, 32'hDEAD_BEEF);
`ifdef IRB_WRITE_BYPASS_EN
    expect_val("wr10_pre_b", SigB, 32'h1234_5678);
`else
    expect_val("wr10_pre_b", SigB, 32'd0);
`endif
    tick();
    reg_wr = 1'b0;
    expect_val("wr10_b", SigB, 32'h1234_5678);
    expect_val("wr10_a", SigA, 32'hDEAD_BEEF);

    // Register 0: rs=0, rt=9, then attempt write of $0
    ir_write = 1'b1; mem_data = 32'h0009_0000;
    tick();
    ir_write = 1'b0;
    reg_wr = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
    expect_val("r0_pre_a", SigA, 32'd0);
    expect_val("r0_pre_b", SigB, 32'hDEAD_BEEF);
    tick();
    reg_wr = 1'b0;
    expect_val("r0_a", SigA, 32'd0);

    // Same-edge IR load and register write
    ir_write = 1'b1; mem_data = 32'h012A_0000;
    reg_wr = 1'b1; write_reg = 5'd10; write_data = 32'hCAFE_0000;
    tick();
    ir_write = 1'b0; reg_wr = 1'b0;
    expect_val("same_a", SigA, 32'hDEAD_BEEF);
    expect_val("same_b", SigB, 32'hCAFE_0000);
    tick();

    // Read-during-write on rs=9
    reg_wr = 1'b1; write_reg = 5'd9; write_data = 32'd5;
`ifdef IRB_WRITE_BYPASS_EN
    expect_val("rdw_pre_a", SigA, 32'd5);
`else
    expect_val("rdw_pre_a", SigA, 32'hDEAD_BEEF);
`endif
    tick();
    reg_wr = 1'b0;
    expect_val("rdw_a", SigA, 32'd5);

    // Mid-operation reset: preload reg5, then reset while a write to reg5 is pending
    ir_write = 1'b1; mem_data = 32'h00BD_0000;
    reg_wr = 1'b1; write_reg = 5'd5; write_data = 32'h55;
    tick();
    ir_write = 1'b0; reg_wr = 1'b0;
    expect_val("pre_rst_a", SigA, 32'h55);
    expect_val("pre_rst_b", SigB, 32'd227);
    tick();
    reg_wr = 1'b1; write_reg = 5'd5; write_data = 32'd7;
    #2;
    reset = 1'b1;
    expect_val("mid_rst_a", SigA, 32'd0);
    expect_val("mid_rst_rs", SigRs, 32'd0);
    expect_val("mid_rst_b", SigB, 32'd0);
    tick();
    reset = 1'b0; reg_wr = 1'b0;
    ir_write = 1'b1; mem_data = 32'h00BD_0000;
    tick();
    ir_write = 1'b0;
    expect_val("post_rst_a", SigA, 32'd0);
    expect_val("post_rst_b", SigB, 32'd227);
    tick();

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sbQ.size() > 0) begin
      nChecks++;
      nErrors++;
      $display("FAIL drain: %0d pending expected 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
